// File: rtl/bram_sd_writer.sv
// Streams a frame of 3-bit pixel bins from a read-latency BRAM into an SD
// controller as 512-byte sectors, one zero-extended pixel per byte.
module bram_sd_writer #(
    parameter int NUM_SECTORS  = 600,
    parameter int BRAM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic [18:0] bram_addr,
    output logic        bram_en,
    input  logic [2:0]  bram_dout,
    input  logic        sd_ready,
    output logic        sd_wr,
    output logic [31:0] sd_address,
    output logic [7:0]  sd_din,
    input  logic        sd_ready_for_next_byte,
    output logic        busy,
    output logic        done,
    output logic [9:0]  sectors_written
);

    typedef enum logic [2:0] {IDLE, PREFETCH, ISSUE, STREAM, FINISH, DONE} state_t;

    localparam logic [18:0] LAST_PIXEL  = 19'(NUM_SECTORS * 512 - 1);
    localparam logic [9:0]  LAST_SECTOR = 10'(NUM_SECTORS - 1);

    state_t                  state;
    logic [18:0]             pixel_ptr;
    logic [8:0]              byte_cnt;
    logic [31:0]             base_q;
    logic                    rfnb_q;
    logic [BRAM_LATENCY-1:0] rd_pipe;
    logic                    have_next;

    logic        byte_rise;
    logic        fetch_busy;
    logic [18:0] ptr_next;

    assign byte_rise  = sd_ready_for_next_byte & ~rfnb_q;
    assign fetch_busy = bram_en | (|rd_pipe);
    // The pointer parks on the final pixel instead of running past the frame.
    assign ptr_next   = (pixel_ptr == LAST_PIXEL) ? pixel_ptr : pixel_ptr + 19'd1;

    function automatic logic [31:0] sector_addr(input logic [31:0] base, input logic [9:0] idx);
        return base + {13'd0, idx, 9'd0};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            pixel_ptr       <= '0;
            byte_cnt        <= '0;
            base_q          <= '0;
            rfnb_q          <= 1'b0;
            rd_pipe         <= '0;
            have_next       <= 1'b0;
            bram_addr       <= '0;
            bram_en         <= 1'b0;
            sd_wr           <= 1'b0;
            sd_address      <= '0;
            sd_din          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            sectors_written <= '0;
        end else begin
            rfnb_q  <= sd_ready_for_next_byte;
            bram_en <= 1'b0;
            for (int i = BRAM_LATENCY - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
            rd_pipe[0] <= bram_en;

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sectors_written <= '0;
                        base_q          <= base_addr & ~32'h1FF;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        have_next       <= 1'b0;
                        // Pointer restarts at 0; pixel 0 is requested right away.
                        bram_en         <= 1'b1;
                        bram_addr       <= '0;
                        pixel_ptr       <= 19'd1;
                        state           <= PREFETCH;
                    end
                end
                PREFETCH: begin
                    if (have_next && sd_ready) begin
                        sd_wr      <= 1'b1;
                        sd_address <= sector_addr(base_q, sectors_written);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!sd_ready) begin
                        sd_wr    <= 1'b0;
                        byte_cnt <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (byte_rise) begin
                        byte_cnt  <= byte_cnt + 9'd1;
                        have_next <= 1'b0;
                        if (byte_cnt == 9'd511) begin
                            state <= FINISH;
                            // Last edge of a sector fetches byte 0 of the next one, if any.
                            if (sectors_written != LAST_SECTOR) begin
                                bram_en   <= 1'b1;
                                bram_addr <= pixel_ptr;
                                pixel_ptr <= ptr_next;
                            end
                        end else begin
                            bram_en   <= 1'b1;
                            bram_addr <= pixel_ptr;
                            pixel_ptr <= ptr_next;
                        end
                    end
                end
                FINISH: begin
                    if (sd_ready && !fetch_busy) begin
                        sectors_written <= sectors_written + 10'd1;
                        if (sectors_written == LAST_SECTOR) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (have_next) begin
                            sd_wr      <= 1'b1;
                            sd_address <= sector_addr(base_q, sectors_written + 10'd1);
                            state      <= ISSUE;
                        end else begin
                            bram_en   <= 1'b1;
                            bram_addr <= pixel_ptr;
                            pixel_ptr <= ptr_next;
                            state     <= PREFETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // NOTE: placed after the case so a landing BRAM word overrides the
            // have_next clear above; with non-blocking assignments the last write wins.
            if (rd_pipe[BRAM_LATENCY-1]) begin
                sd_din    <= {5'b0, bram_dout};
                have_next <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bram_sd_writer.sv
// Bench for bram_sd_writer: a 1-sector and a 7-sector instance share one
// SD-controller BFM and BRAM model, selected by sel; expectations go through queues.
module tb_bram_sd_writer;

    localparam int LAT           = 2;
    localparam int FRAME_SECTORS = 7;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, sd_ready, rfnb, sel;
    logic [31:0] base_addr;
    logic [2:0]  bram_dout;
    logic        start_f, start_s;

    logic [18:0] f_baddr, s_baddr;
    logic        f_en, s_en, f_wr, s_wr, f_busy, s_busy, f_done, s_done;
    logic [31:0] f_addr, s_addr;
    logic [7:0]  f_din, s_din;
    logic [9:0]  f_sw, s_sw;

    logic [18:0] act_baddr;
    logic        act_en, act_wr, act_busy, act_done;
    logic [31:0] act_addr;
    logic [7:0]  act_din;
    logic [9:0]  act_sw;

    assign start_f = start & ~sel;
    assign start_s = start & sel;

    bram_sd_writer #(.NUM_SECTORS(FRAME_SECTORS), .BRAM_LATENCY(LAT)) dut_f (
        .clk(clk), .reset_n(reset_n), .start(start_f), .base_addr(base_addr),
        .bram_addr(f_baddr), .bram_en(f_en), .bram_dout(bram_dout),
        .sd_ready(sd_ready), .sd_wr(f_wr), .sd_address(f_addr), .sd_din(f_din),
        .sd_ready_for_next_byte(rfnb), .busy(f_busy), .done(f_done),
        .sectors_written(f_sw));

    bram_sd_writer #(.NUM_SECTORS(1), .BRAM_LATENCY(LAT)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start_s), .base_addr(base_addr),
        .bram_addr(s_baddr), .bram_en(s_en), .bram_dout(bram_dout),
        .sd_ready(sd_ready), .sd_wr(s_wr), .sd_address(s_addr), .sd_din(s_din),
        .sd_ready_for_next_byte(rfnb), .busy(s_busy), .done(s_done),
        .sectors_written(s_sw));

    always_comb begin
        act_baddr = sel ? s_baddr : f_baddr;
        act_en    = sel ? s_en    : f_en;
        act_wr    = sel ? s_wr    : f_wr;
        act_addr  = sel ? s_addr  : f_addr;
        act_din   = sel ? s_din   : f_din;
        act_busy  = sel ? s_busy  : f_busy;
        act_done  = sel ? s_done  : f_done;
        act_sw    = sel ? s_sw    : f_sw;
    end

    // Single sector uses pixel[i] = i % 8; the frame mixes in sector bits.
    function automatic logic [2:0] pix(input logic s, input logic [18:0] a);
        return s ? a[2:0] : (a[2:0] ^ a[5:3] ^ a[11:9]);
    endfunction

    // BRAM model: data for an enabled address appears LAT cycles later.
    logic [2:0] mem_q [LAT];
    always @(posedge clk) begin
        if (act_en) mem_q[0] <= pix(sel, act_baddr);
        for (int i = 1; i < LAT; i++) mem_q[i] <= mem_q[i-1];
    end
    assign bram_dout = mem_q[LAT-1];

    int   range_err = 0;
    int   wr_rises  = 0;
    logic wr_q      = 1'b0;
    always @(posedge clk) begin
        if (act_en && act_baddr > (sel ? 19'd511 : 19'(FRAME_SECTORS * 512 - 1))) range_err++;
        if (act_wr && !wr_q) wr_rises++;
        wr_q <= act_wr;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] addr_q [$];
    logic [7:0]  byte_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int nsec, input logic [31:0] base, input logic s);
        for (int sec = 0; sec < nsec; sec++) begin
            addr_q.push_back({base[31:9], 9'd0} + 32'(sec * 512));
            for (int b = 0; b < 512; b++) byte_q.push_back({5'b0, pix(s, 19'(sec * 512 + b))});
        end
    endtask

    task automatic pulse_start(input string name);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (act_busy !== 1'b1 || act_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b, required busy=1 done=0", name, act_busy, act_done);
        end
    endtask

    // SD controller BFM; optionally asserts reset or pulses start at a chosen byte.
    task automatic bfm(input int nsec, input int hold, input int gap, input int rdy_delay,
                       input int rst_sec, input int rst_byte, input int start_sec);
        int          wait_cyc;
        logic        held, quiet, stable;
        logic [31:0] exp_a;
        logic [7:0]  exp_b;
        for (int s = 0; s < nsec; s++) begin
            wait_cyc = 0;
            while (act_wr !== 1'b1 && wait_cyc < 2000) begin
                step();
                wait_cyc++;
            end
            checks++;
            if (act_wr !== 1'b1) begin
                errors++;
                $display("FAIL wr_timeout sector %0d: sd_wr=%b after %0d cycles, required 1", s, act_wr, wait_cyc);
                return;
            end
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL extra_request sector %0d: sd_address=%h, required no request", s, act_addr);
                return;
            end
            exp_a = addr_q.pop_front();
            if (act_addr !== exp_a) begin
                errors++;
                $display("FAIL sd_address sector %0d: got %h, required %h", s, act_addr, exp_a);
            end
            checks++;
            if (act_sw !== 10'(s)) begin
                errors++;
                $display("FAIL sectors_written at issue %0d: got %0d, required %0d", s, act_sw, s);
            end
            held = 1'b1;
            for (int d = 0; d < rdy_delay; d++) begin
                step();
                if (act_wr !== 1'b1) held = 1'b0;
            end
            checks++;
            if (!held) begin
                errors++;
                $display("FAIL wr_hold sector %0d: sd_wr dropped while sd_ready=1, required held", s);
            end
            sd_ready = 1'b0;
            step();
            checks++;
            if (act_wr !== 1'b0) begin
                errors++;
                $display("FAIL wr_drop sector %0d: sd_wr=%b, required 0", s, act_wr);
            end
            quiet  = 1'b1;
            stable = 1'b1;
            for (int b = 0; b < 512; b++) begin
                if (s == rst_sec && b == rst_byte) begin
                    reset_n = 1'b0;
                    step();
                    checks++;
                    if ({act_wr, act_busy, act_done, act_en, act_sw, act_din, act_addr, act_baddr} !== '0) begin
                        errors++;
                        $display("FAIL reset_state: wr=%b busy=%b done=%b en=%b sw=%0d din=%h addr=%h baddr=%h, required all 0",
                                 act_wr, act_busy, act_done, act_en, act_sw, act_din, act_addr, act_baddr);
                    end
                    reset_n  = 1'b1;
                    sd_ready = 1'b1;
                    rfnb     = 1'b0;
                    return;
                end
                exp_b = (byte_q.size() != 0) ? byte_q.pop_front() : 8'hxx;
                checks++;
                if (act_din !== exp_b) begin
                    errors++;
                    $display("FAIL sd_din sector %0d byte %0d: got %h, required %h", s, b, act_din, exp_b);
                end
                if (s == start_sec && b == 100) begin
                    start = 1'b1;
                    step();
                    start = 1'b0;
                    checks++;
                    if (act_busy !== 1'b1 || act_sw !== 10'(s)) begin
                        errors++;
                        $display("FAIL start_ignored: busy=%b sw=%0d, required busy=1 sw=%0d", act_busy, act_sw, s);
                    end
                end
                rfnb = 1'b1;
                for (int c = 0; c < gap; c++) begin
                    if (c == hold) rfnb = 1'b0;
                    step();
                    if (act_wr !== 1'b0) quiet = 1'b0;
                    if (act_addr !== exp_a) stable = 1'b0;
                end
            end
            checks++;
            if (!quiet || !stable) begin
                errors++;
                $display("FAIL stream_quiet sector %0d: wr_quiet=%b addr_stable=%b, required 1 1", s, quiet, stable);
            end
            step();
            step();
            sd_ready = 1'b1;
        end
    endtask

    task automatic wait_done(input string name);
        int wait_cyc = 0;
        while (act_done !== 1'b1 && wait_cyc < 200) begin
            step();
            wait_cyc++;
        end
        checks++;
        if (act_done !== 1'b1 || act_busy !== 1'b0 || act_wr !== 1'b0) begin
            errors++;
            $display("FAIL %s: done=%b busy=%b wr=%b, required 1 0 0", name, act_done, act_busy, act_wr);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; start = 1'b0; sd_ready = 1'b1; rfnb = 1'b0; base_addr = '0;
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({f_wr, f_en, f_busy, f_done, f_sw, f_din, f_addr, f_baddr} !== '0) begin
            errors++;
            $display("FAIL reset_frame_dut: wr=%b en=%b busy=%b done=%b sw=%0d din=%h addr=%h baddr=%h, required all 0",
                     f_wr, f_en, f_busy, f_done, f_sw, f_din, f_addr, f_baddr);
        end
        checks++;
        if ({s_wr, s_en, s_busy, s_done, s_sw, s_din, s_addr, s_baddr} !== '0) begin
            errors++;
            $display("FAIL reset_single_dut: wr=%b en=%b busy=%b done=%b sw=%0d din=%h addr=%h baddr=%h, required all 0",
                     s_wr, s_en, s_busy, s_done, s_sw, s_din, s_addr, s_baddr);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_sector();
        int wr0;
        sel = 1'b1;
        base_addr = 32'h0000_1234;
        push_frame(1, base_addr, 1'b1);
        wr0 = wr_rises;
        pulse_start("single_start");
        bfm(1, 1, 8, 100, -1, -1, -1);
        wait_done("single_done");
        checks++;
        if (act_sw !== 10'd1 || wr_rises - wr0 != 1) begin
            errors++;
            $display("FAIL single_counts: sw=%0d requests=%0d, required 1 1", act_sw, wr_rises - wr0);
        end
    endtask

    task automatic test_full_frame();
        int wr0;
        sel = 1'b0;
        base_addr = 32'h0010_0377;
        push_frame(FRAME_SECTORS, base_addr, 1'b0);
        wr0 = wr_rises;
        pulse_start("frame_start");
        bfm(FRAME_SECTORS, 3, 8, 1, -1, -1, 5);
        wait_done("frame_done");
        checks++;
        if (act_sw !== 10'(FRAME_SECTORS) || wr_rises - wr0 != FRAME_SECTORS) begin
            errors++;
            $display("FAIL frame_counts: sw=%0d requests=%0d, required %0d %0d",
                     act_sw, wr_rises - wr0, FRAME_SECTORS, FRAME_SECTORS);
        end
        checks++;
        if (act_din !== {5'b0, pix(1'b0, 19'(FRAME_SECTORS * 512 - 1))} || addr_q.size() != 0 || byte_q.size() != 0) begin
            errors++;
            $display("FAIL frame_tail: last din=%h left addr=%0d bytes=%0d, required %h 0 0",
                     act_din, addr_q.size(), byte_q.size(), {5'b0, pix(1'b0, 19'(FRAME_SECTORS * 512 - 1))});
        end
    endtask

    task automatic test_reset_mid_stream();
        int wr0;
        sel = 1'b0;
        base_addr = 32'hABCD_E000;
        addr_q.delete();
        byte_q.delete();
        push_frame(FRAME_SECTORS, base_addr, 1'b0);
        pulse_start("restart_from_done");
        bfm(FRAME_SECTORS, 1, 8, 2, 3, 200, -1);
        addr_q.delete();
        byte_q.delete();
        step();
        push_frame(2, base_addr, 1'b0);
        wr0 = wr_rises;
        pulse_start("start_after_reset");
        bfm(2, 1, 8, 2, 1, 0, -1);
        checks++;
        if (wr_rises - wr0 != 2) begin
            errors++;
            $display("FAIL rewrite_requests: got %0d, required 2", wr_rises - wr0);
        end
        addr_q.delete();
        byte_q.delete();
    endtask

    task automatic test_bram_range();
        checks++;
        if (range_err != 0) begin
            errors++;
            $display("FAIL bram_range: %0d reads past final pixel, required 0", range_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_sector();
        test_full_frame();
        test_reset_mid_stream();
        test_bram_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_sd_writer.md
BRAM_SD_WRITER -- requirements
Module: bram_sd_writer

Interface
REQ-001 Parameter NUM_SECTORS, default 600, meaning sectors per frame (640x480 pixels / 512 bytes).
REQ-002 Parameter BRAM_LATENCY, default 2, meaning cycles from bram_addr to valid bram_dout.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1, the single clock, the 25 MHz SD clock.
REQ-005 Port reset_n, input, 1, synchronous active-low reset.
REQ-006 Port start, input, 1, one-cycle request to dump the frame.
REQ-007 Port base_addr, input, 32, SD byte address of sector 0; bits [8:0] are ignored and treated as 0.
REQ-008 Port bram_addr, output, 19, xy_bin read address.
REQ-009 Port bram_en, output, 1, BRAM read enable.
REQ-010 Port bram_dout, input, 3, pixel bin value.
REQ-011 Port sd_ready, input, 1, sd_controller idle and ready.
REQ-012 Port sd_wr, output, 1, write request to sd_controller.
REQ-013 Port sd_address, output, 32, sector byte address.
REQ-014 Port sd_din, output, 8, write data byte.
REQ-015 Port sd_ready_for_next_byte, input, 1, controller has sampled sd_din.
REQ-016 Port busy, output, 1, transfer in progress.
REQ-017 Port done, output, 1, frame fully written.
REQ-018 Port sectors_written, output, 10, completed-sector count.

Function
REQ-019 Byte mapping SHALL be: byte k of sector s = {5'b0, pixel[s*512+k]}, where pixel[i] is read from bram_addr i (19-bit, 0..307199).
REQ-020 The FSM states SHALL be IDLE, PREFETCH, ISSUE, STREAM, FINISH, DONE.
REQ-021 IDLE: on start=1, the FSM SHALL clear sectors_written and the pixel pointer, latch base_addr, set busy=1, and go to PREFETCH.
REQ-022 PREFETCH: the block SHALL drive bram_en=1 with the pointer address, wait BRAM_LATENCY cycles, and register bram_dout into sd_din.
REQ-023 PREFETCH SHALL then advance the pointer and go to ISSUE once sd_ready=1.
REQ-024 ISSUE: sd_address SHALL equal latched_base + sectors_written*512, and sd_wr SHALL be held at 1 until sd_ready=0 is observed.
REQ-025 In the cycle after sd_ready=0 is observed, sd_wr SHALL drop to 0 and the FSM SHALL enter STREAM with byte counter = 0.
REQ-026 STREAM: the block SHALL act only on the rising edge of sd_ready_for_next_byte (registered previous value); a level held high SHALL count once.
REQ-027 On each rising edge, the byte counter SHALL increment, and the next pixel SHALL be read and loaded into sd_din within BRAM_LATENCY+1 cycles (must be < 8, one SPI byte).
REQ-028 sd_din SHALL be stable at all other times.
REQ-029 After the 512th rising edge (counter wrap 511->0), the FSM SHALL enter FINISH and issue no further BRAM reads for this sector.
REQ-030 FINISH: on sd_ready=1, sectors_written SHALL increment.
REQ-031 FINISH SHALL then go to DONE if sectors_written reaches NUM_SECTORS, else to ISSUE when the next byte is already prefetched, otherwise to PREFETCH.
REQ-032 DONE: done=1, busy=0; the state SHALL persist until the next start, which restarts from IDLE semantics (done cleared the same cycle).
REQ-033 start while busy=1 SHALL be ignored.
REQ-034 The pixel pointer SHALL never exceed NUM_SECTORS*512-1, and no BRAM read SHALL be issued past the final pixel.
REQ-035 sd_wr SHALL never be asserted outside ISSUE.
REQ-036 sd_address SHALL stay constant from ISSUE entry until the end of FINISH.

Reset
REQ-037 reset_n=0 at a clock edge SHALL force, on the next cycle, state IDLE, sd_wr=0, bram_en=0, sd_din=0, sd_address=0, bram_addr=0, busy=0, done=0, sectors_written=0, byte counter=0 and pointer=0.
REQ-038 Reset mid-STREAM SHALL abandon the sector with no further sd_wr; sd_controller recovery is outside this block.

Verification
REQ-039 Single sector (NUM_SECTORS=1): BRAM pattern pixel[i]=i%8, base_addr=0x1234 -> sd_address=0x1200, one sd_wr, 512 bytes 00..07 repeating, done=1, sectors_written=1.
REQ-040 Full frame (default): BFM controller with 10-cycle byte spacing -> exactly 600 sd_wr, addresses base+0 .. base+599*512, last byte = pixel[307199], and no bram_addr > 307199.
REQ-041 ready_for_next_byte held high 3 cycles per byte -> byte counter increments once per pulse, and 512 bytes per sector exactly.
REQ-042 start pulsed during STREAM of sector 5 -> ignored, with sectors_written continuing 6, 7, ...
REQ-043 reset_n low during sector 3 byte 200 -> next cycle sd_wr=0, busy=0, sectors_written=0; a subsequent start rewrites from base_addr, sector 0.
REQ-044 sd_ready delayed 100 cycles after wr -> sd_wr stays 1 throughout and drops the cycle after sd_ready=0, with no duplicate request.
